// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ byte producers share one uart_tx.
// One byte in flight at a time, with a done timeout and an optional idle gap after each byte.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [8*N_REQ-1:0]       req_data_i,
    output logic [N_REQ-1:0]         req_ack_o,
    output logic                     tx_start_o,
    output logic [7:0]               tx_din_o,
    input  logic                     tx_done_tick_i,
    output logic                     busy_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     timeout_err_o,
    output logic [1:0]               state_o
);
    localparam int          IW       = $clog2(N_REQ);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

    // Handshake: a requester raises req_valid and holds data until it sees a one-cycle
    // req_ack; the tx side gets a one-cycle tx_start and answers with tx_done_tick.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              start_q, start_d;
    logic [7:0]        din_q, din_d;
    logic [IW-1:0]     gid_q, gid_d;
    logic              terr_q, terr_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [IW-1:0]     last_q, last_d;

    logic              found;
    logic [IW-1:0]     pick;

    // Search begins one past the last completed grant, wrapping at N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            int            idx;
            logic [IW-1:0] cand;
            idx = int'(last_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IW'(idx);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        start_d = 1'b0;
        din_d   = din_q;
        gid_d   = gid_q;
        terr_d  = 1'b0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = START;
                    ack_d[pick] = 1'b1;
                    start_d     = 1'b1;
                    din_d       = req_data_i[{pick, 3'b000} +: 8];
                    gid_d       = pick;
                end
            end
            START: begin
                state_d = WAIT_DONE;
                cnt_d   = '0;
            end
            WAIT_DONE: begin
                // A done arriving on the timeout cycle still counts as a clean completion.
                if (tx_done_tick_i || cnt_q == TO_LAST) begin
                    last_d  = gid_q;
                    terr_d  = !tx_done_tick_i;
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ack_q   <= '0;
            start_q <= 1'b0;
            din_q   <= 8'h00;
            gid_q   <= '0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            din_q   <= din_d;
            gid_q   <= gid_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign req_ack_o     = ack_q;
    assign tx_start_o    = start_q;
    assign tx_din_o      = din_q;
    assign grant_id_o    = gid_q;
    assign timeout_err_o = terr_q;
    assign busy_o        = (state_q != IDLE);
    assign state_o       = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized request sets checked
// against a round-robin reference model and an expected-byte queue.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: four requesters, 16-cycle gap, short timeout.
    logic        a_reset, a_start, a_done, a_busy, a_terr;
    logic [3:0]  a_valid, a_ack;
    logic [31:0] a_data;
    logic [7:0]  a_din;
    logic [1:0]  a_gid, a_state;

    // Instance B: two requesters, no gap, timeout 20.
    logic        b_reset, b_start, b_done, b_busy, b_terr;
    logic [1:0]  b_valid, b_ack, b_state;
    logic [15:0] b_data;
    logic [7:0]  b_din;
    logic [0:0]  b_gid;

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(100)) dut_a (
        .clk_i(clk), .reset_i(a_reset), .req_valid_i(a_valid), .req_data_i(a_data),
        .req_ack_o(a_ack), .tx_start_o(a_start), .tx_din_o(a_din), .tx_done_tick_i(a_done),
        .busy_o(a_busy), .grant_id_o(a_gid), .timeout_err_o(a_terr), .state_o(a_state)
    );

    uart_tx_arbiter #(.N_REQ(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)) dut_b (
        .clk_i(clk), .reset_i(b_reset), .req_valid_i(b_valid), .req_data_i(b_data),
        .req_ack_o(b_ack), .tx_start_o(b_start), .tx_din_o(b_din), .tx_done_tick_i(b_done),
        .busy_o(b_busy), .grant_id_o(b_gid), .timeout_err_o(b_terr), .state_o(b_state)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         exp_gid_q[$];
    int         obs_gid_q[$];
    int         ack_cnt[4];
    int         terr_cnt;
    int         m_last;
    logic [3:0] sticky;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first valid requester after the last completed grant, cyclically.
    function automatic int rr_next(input logic [3:0] mask, input int last);
        for (int k = 1; k <= 4; k++)
            if (mask[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic predict(input logic [3:0] mask);
        logic [3:0] m;
        int g;
        m = mask;
        while (m != 4'b0) begin
            g = rr_next(m, m_last);
            exp_q.push_back(a_data[8*g +: 8]);
            exp_gid_q.push_back(g);
            m[g] = 1'b0;
            m_last = g;
        end
    endtask

    task automatic clear_sb();
        exp_q.delete(); obs_q.delete(); exp_gid_q.delete(); obs_gid_q.delete();
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        terr_cnt = 0;
    endtask

    task automatic compare_sb(input string tag);
        logic [7:0] e, o;
        int eg, og;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            eg = exp_gid_q.pop_front();
            o  = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            og = (obs_gid_q.size() > 0) ? obs_gid_q.pop_front() : -1;
            check({tag, "_byte"}, 32'(o), 32'(e));
            check({tag, "_gid"}, 32'(og), 32'(eg));
        end
    endtask

    task automatic reset_a();
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        m_last = 3;
        clear_sb();
    endtask

    // Acts as requesters (drop valid on ack unless sticky) and as a uart_tx with fixed latency.
    task automatic run_auto(input int lat, input int max_grants, input int budget, output bit ok);
        int cnt, grants;
        cnt = -1; grants = 0; ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            a_done = 1'b0;
            for (int i = 0; i < 4; i++)
                if (a_ack[i] && !sticky[i]) a_valid[i] = 1'b0;
            if (a_start) begin
                grants++;
                cnt = lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    a_done = 1'b1;
                    cnt = -1;
                end
            end
            if (grants >= max_grants && !a_busy && cnt < 0 && !a_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!a_reset) begin
            if (a_ack != 4'b0 || a_start)
                check("ack_with_start", 32'(a_start && $onehot(a_ack)), 32'd1);
            if (a_start) begin
                obs_q.push_back(a_din);
                obs_gid_q.push_back(int'(a_gid));
            end
            for (int i = 0; i < 4; i++) if (a_ack[i]) ack_cnt[i]++;
            if (a_terr) terr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat;
        bit ok;
        logic [3:0] mask;
        a_reset = 1'b1; a_valid = '0; a_data = '0; a_done = 1'b0;
        b_reset = 1'b1; b_valid = '0; b_data = '0; b_done = 1'b0;
        sticky = '0;
        clear_sb();
        tick(); tick();
        check("rst_ack", 32'(a_ack), 32'd0);
        check("rst_start", 32'(a_start), 32'd0);
        check("rst_din", 32'(a_din), 32'h00);
        check("rst_gid", 32'(a_gid), 32'd0);
        check("rst_terr", 32'(a_terr), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_state", 32'(a_state), 32'd0);
        a_reset = 1'b0; b_reset = 1'b0; m_last = 3;

        // Single byte with one-cycle grant latency and a 16-cycle gap after done.
        a_valid = 4'b0001; a_data[7:0] = 8'hF0;
        predict(4'b0001);
        tick();
        check("sb_ack", 32'(a_ack), 32'b0001);
        check("sb_start", 32'(a_start), 32'd1);
        check("sb_din", 32'(a_din), 32'hF0);
        check("sb_gid", 32'(a_gid), 32'd0);
        check("sb_busy", 32'(a_busy), 32'd1);
        a_valid = 4'b0000;
        tick();
        check("sb_ack_clr", 32'(a_ack), 32'd0);
        check("sb_start_clr", 32'(a_start), 32'd0);
        check("sb_wait", 32'(a_state), 32'd2);
        repeat (5) tick();
        check("sb_busy_wait", 32'(a_busy), 32'd1);
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        check("sb_gap", 32'(a_state), 32'd3);
        n = 0;
        while (a_busy && n < 100) begin tick(); n++; end
        check("sb_gap_len", 32'(n), 32'd16);
        check("sb_din_hold", 32'(a_din), 32'hF0);
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        check("idle_ignores_done", 32'(a_state), 32'd0);
        compare_sb("single");

        // Round robin from reset: all four pending.
        reset_a();
        a_data = 32'h44332211; a_valid = 4'hF;
        predict(4'hF);
        run_auto(3, 4, 400, ok);
        check("rr_finished", 32'(ok), 32'd1);
        compare_sb("rr");
        for (int i = 0; i < 4; i++) check("rr_one_ack", 32'(ack_cnt[i]), 32'd1);

        // Fairness between two continuously valid requesters.
        clear_sb();
        a_data = 32'h00BB00AA; a_valid = 4'b0101; sticky = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            n = rr_next(4'b0101, m_last);
            exp_q.push_back(a_data[8*n +: 8]);
            exp_gid_q.push_back(n);
            m_last = n;
        end
        run_auto(2, 4, 600, ok);
        a_valid = 4'b0000; sticky = 4'b0000;
        check("fair_finished", 32'(ok), 32'd1);
        compare_sb("fair");

        // Timeout with no done: pulse 100 cycles after WAIT_DONE entry, then gap.
        clear_sb();
        a_data[15:8] = 8'h5A; a_valid = 4'b0010;
        predict(4'b0010);
        tick();
        a_valid = 4'b0000;
        tick();
        n = 0;
        while (!a_terr && n < 1000) begin tick(); n++; end
        check("to_latency", 32'(n), 32'd100);
        check("to_gap", 32'(a_state), 32'd3);
        tick();
        check("to_pulse_len", 32'(a_terr), 32'd0);
        n = 1;
        while (a_busy && n < 100) begin tick(); n++; end
        check("to_gap_len", 32'(n), 32'd16);
        check("to_terr_cnt", 32'(terr_cnt), 32'd1);
        compare_sb("timeout");

        // Reset in the middle of a byte; the pending request goes out cleanly afterwards.
        clear_sb();
        a_data[7:0] = 8'hFF; a_valid = 4'b0001;
        tick();
        check("rb_first_ack", 32'(a_ack), 32'b0001);
        a_valid = 4'b0010; a_data[15:8] = 8'hCC;
        repeat (4) tick();
        check("rb_in_wait", 32'(a_state), 32'd2);
        a_reset = 1'b1;
        tick();
        check("rb_ack", 32'(a_ack), 32'd0);
        check("rb_start", 32'(a_start), 32'd0);
        check("rb_din", 32'(a_din), 32'h00);
        check("rb_gid", 32'(a_gid), 32'd0);
        check("rb_busy", 32'(a_busy), 32'd0);
        a_reset = 1'b0; m_last = 3;
        clear_sb();
        predict(4'b0010);
        run_auto(2, 1, 200, ok);
        check("rb_finished", 32'(ok), 32'd1);
        compare_sb("rb");
        check("rb_no_stray_ack", 32'(ack_cnt[0]), 32'd0);
        check("rb_one_ack", 32'(ack_cnt[1]), 32'd1);
        check("rb_no_terr", 32'(terr_cnt), 32'd0);

        // Randomized request sets against the round-robin model.
        for (int it = 0; it < 6; it++) begin
            clear_sb();
            mask = 4'($urandom_range(1, 15));
            a_data = $urandom;
            a_valid = mask;
            predict(mask);
            lat = $urandom_range(1, 6);
            run_auto(lat, $countones(mask), 800, ok);
            check("rand_finished", 32'(ok), 32'd1);
            compare_sb("rand");
            for (int i = 0; i < 4; i++) check("rand_ack_cnt", 32'(ack_cnt[i]), 32'(mask[i]));
        end

        // No gap: done on the timeout cycle wins and returns straight to IDLE.
        b_data[15:8] = 8'hA5; b_valid = 2'b10;
        tick();
        check("b_ack", 32'(b_ack), 32'b10);
        check("b_gid", 32'(b_gid), 32'd1);
        check("b_din", 32'(b_din), 32'hA5);
        b_valid = 2'b00;
        tick();
        repeat (19) tick();
        check("b_pre_state", 32'(b_state), 32'd2);
        check("b_pre_terr", 32'(b_terr), 32'd0);
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        check("b_coinc_state", 32'(b_state), 32'd0);
        check("b_coinc_busy", 32'(b_busy), 32'd0);
        check("b_coinc_terr", 32'(b_terr), 32'd0);
        tick();
        check("b_coinc_terr_after", 32'(b_terr), 32'd0);

        // No gap: plain timeout returns straight to IDLE.
        b_data[7:0] = 8'h3C; b_valid = 2'b01;
        tick();
        check("b2_gid", 32'(b_gid), 32'd0);
        b_valid = 2'b00;
        tick();
        n = 0;
        while (!b_terr && n < 200) begin tick(); n++; end
        check("b2_latency", 32'(n), 32'd20);
        check("b2_idle", 32'(b_state), 32'd0);
        check("b2_busy", 32'(b_busy), 32'd0);
        check("b2_din_hold", 32'(b_din), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of byte requesters sharing one uart_tx (range 2..8).
REQ-002 Parameter GAP_CYCLES, default 16, idle clk cycles inserted after each byte (0 allowed).
REQ-003 Parameter TIMEOUT_CYCLES, default 200000, max clk cycles waiting for tx_done_tick (must be >0).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  N_REQ  bit i high: requester i has a byte pending; held until its ack.
REQ-007 req_data  input  8*N_REQ  byte of requester i on bits [8i+7:8i]; stable while req_valid[i] high.
REQ-008 req_ack  output  N_REQ  one-cycle pulse: requester i byte accepted.
REQ-009 tx_start  output  1  one-cycle start pulse to uart_tx.
REQ-010 tx_din  output  8  byte to uart_tx; held stable from tx_start until return to IDLE.
REQ-011 tx_done_tick  input  1  uart_tx completion pulse.
REQ-012 busy  output  1  high whenever state != IDLE.
REQ-013 grant_id  output  clog2(N_REQ)  index of requester owning current transfer.
REQ-014 timeout_err  output  1  one-cycle pulse when a transfer times out.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT_DONE, GAP; all outputs registered.
REQ-016 IDLE, any req_valid high: grant requester chosen round-robin, search starting at last_grant+1 modulo N_REQ.
REQ-017 On grant edge: tx_din <= granted byte, grant_id <= index, req_ack[index] <= 1, tx_start <= 1, state <= START.
REQ-018 Latency: req_valid sampled in IDLE at edge k -> req_ack and tx_start high in cycle k+1 (same cycle).
REQ-019 START lasts exactly one cycle, then WAIT_DONE; req_ack and tx_start return to 0.
REQ-020 tx_done_tick SHALL be ignored in IDLE, START and GAP.
REQ-021 WAIT_DONE: on tx_done_tick, go to GAP (GAP_CYCLES>0) or directly to IDLE (GAP_CYCLES=0); last_grant <= grant_id.
REQ-022 WAIT_DONE: 32-bit cycle counter, cleared on entry; on reaching TIMEOUT_CYCLES without tx_done_tick -> timeout_err pulse 1 cycle, last_grant <= grant_id, state to GAP/IDLE as in REQ-021.
REQ-023 tx_done_tick on same cycle counter reaches TIMEOUT_CYCLES: done wins, no timeout_err.
REQ-024 GAP: count exactly GAP_CYCLES cycles, then IDLE; requests arriving during GAP wait.
REQ-025 At most one req_ack bit high in any cycle; no requester acked twice per byte.
REQ-026 Single active requester SHALL be re-granted each round, no starvation of others: any continuously valid requester granted within N_REQ transfers.
REQ-027 req_valid deasserted before grant: no ack, no transfer.
REQ-028 tx_din, grant_id hold values in GAP and IDLE until next grant.

Reset
REQ-029 reset high at an edge: state IDLE, req_ack 0, tx_start 0, tx_din 0x00, grant_id 0, timeout_err 0, busy 0, counters 0, last_grant N_REQ-1 (requester 0 highest priority next).
REQ-030 reset mid-transfer aborts immediately; no ack, tx_start or timeout_err produced for the aborted byte; pending requests re-arbitrated after reset release.

Verification
REQ-031 Single byte: req_valid[0]=1, data 0xF0 -> ack[0] and tx_start one cycle, tx_din=0xF0, grant_id=0, busy until tx_done_tick + 16 cycles.
REQ-032 Round robin: all four valid with 0x11,0x22,0x33,0x44 held until acked -> uart line order 0x11,0x22,0x33,0x44, each exactly one ack.
REQ-033 Fairness: req 0 and 2 continuously valid -> grants alternate 0,2,0,2.
REQ-034 Timeout: tx_done_tick tied 0, TIMEOUT_CYCLES=100 -> timeout_err pulse exactly 100 cycles after WAIT_DONE entry, then GAP, IDLE.
REQ-035 Reset mid-byte: reset during WAIT_DONE with 0xFF -> all outputs reset values next cycle; after release, pending 0xCC from req 1 sent with no stray ack.
REQ-036 Boundary: GAP_CYCLES=0 and tx_done_tick coincident with timeout -> direct IDLE, no timeout_err.
